serializador_4bits: RTL and testbench
=====================================

SERIALIZADOR_4BITS -- requirements
Module: serializador_4bits

Interface
REQ-001 Parameter NBITS_REG, default 4, SHALL set the data word width in bits.
REQ-002 Parameter BIT_CYCLES, default 1, SHALL set the clock cycles each serial bit is held (legal range 1..255).
REQ-003 Port clk_2, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the synchronous, active-high reset.
REQ-005 Port start, input, 1, SHALL be the level-sampled request to transmit dado_paralelo.
REQ-006 Port dado_paralelo, input, NBITS_REG, SHALL be the parallel word to transmit.
REQ-007 Port serial_out, output, 1, SHALL be the serial line; idle level 1.
REQ-008 Port busy, output, 1, SHALL be high while a frame is on the line.
REQ-009 Port done, output, 1, SHALL be a one-cycle pulse marking frame completion.
REQ-010 Port seg, output, 8, SHALL carry the 7-segment code of the latched word.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; encoding is free.
REQ-012 Frame SHALL be: start bit 0, then NBITS_REG data bits LSB first, then stop bit 1.
REQ-013 Each bit SHALL be held for exactly BIT_CYCLES cycles, timed by a bit-cycle counter.
REQ-014 Frame length SHALL be (NBITS_REG+2)*BIT_CYCLES cycles; busy SHALL be high for exactly those cycles.
REQ-015 IDLE: serial_out=1, busy=0. At a rising edge with start=1, the FSM SHALL latch dado_paralelo into the shift register and enter START.
REQ-016 START SHALL drive serial_out=0 and enter DATA after BIT_CYCLES cycles.
REQ-017 DATA SHALL drive serial_out = shift-register bit 0. After each bit time, the register SHALL shift right and a bit index SHALL increment. After bit NBITS_REG-1 the FSM SHALL enter STOP.
REQ-018 STOP SHALL drive serial_out=1 and enter IDLE after BIT_CYCLES cycles.
REQ-019 done SHALL be 1 for exactly the first cycle in IDLE after STOP, and 0 otherwise.
REQ-020 start SHALL be ignored while busy=1; no queuing.
REQ-021 Changes on dado_paralelo after acceptance SHALL NOT affect the frame in flight.
REQ-022 Back-to-back: start=1 in the done cycle SHALL be accepted, so the next START begins the following cycle (one idle-1 cycle between frames).
REQ-023 serial_out, busy and done SHALL be registered outputs with no combinational path from inputs.
REQ-024 seg SHALL decode a separate display register that is loaded with the word on acceptance and persists after the frame ends.
REQ-025 seg codes for 0..F SHALL be: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-026 Bit index and bit-cycle counter SHALL reset to 0 on every state entry; no wrap beyond the terminal count.

Reset
REQ-027 reset=1 at a rising edge SHALL force, on the next cycle: state IDLE, serial_out=1, busy=0, done=0, shift register 0, display register 0 (seg=3F), counters 0.
REQ-028 reset SHALL take priority over start and over any frame in progress. An aborted frame SHALL NOT produce done.
REQ-029 With reset and start both high, start SHALL be ignored.

Verification (BIT_CYCLES=1 unless stated)
REQ-030 After reset: serial_out=1, busy=0, done=0, seg=3F, held with start=0 for 10 cycles.
REQ-031 dado_paralelo=4'hB, start pulsed 1 cycle at edge E0 -> serial_out after E0..E5 = 0,1,1,0,1,1; busy=1 for those 6 cycles; done=1 only after E6; seg=7C from after E0.
REQ-032 start held high continuously, dado_paralelo=4'h5 -> frames 0,1,0,1,0,1 repeat every 7 cycles with one idle-1 cycle between; done pulses once per frame.
REQ-033 dado_paralelo changed to 4'h0 and start pulsed mid-frame of 4'hA -> 4'hA frame completes unaltered; the second start is ignored.
REQ-034 reset asserted at the 3rd data bit of 4'hF -> serial_out=1, busy=0, seg=3F next cycle; no done pulse.
REQ-035 BIT_CYCLES=3, dado_paralelo=4'h2 -> each level held 3 cycles: 000 000 111 000 000 111; busy high 18 cycles.

Source files
------------

// File: rtl/serializador_4bits.sv
// ---------------------------------------------------------------------------
// serializador_4bits
//   Parallel-to-serial transmitter with a UART-like frame:
//   one start bit (0), NBITS_REG data bits LSB first, one stop bit (1).
//   Every bit is held on the line for BIT_CYCLES clocks. The last accepted
//   word is kept in a display register and shown on a 7-segment decoder.
//
// Ports
//   clk_2         in   1          clock, rising edge
//   reset         in   1          synchronous reset, active high
//   start         in   1          level-sampled transmit request (IDLE only)
//   dado_paralelo in   NBITS_REG  word to transmit
//   serial_out    out  1          serial line, idles high (registered)
//   busy          out  1          high while a frame is on the line (registered)
//   done          out  1          one-cycle pulse after the stop bit (registered)
//   seg           out  8          7-segment code of the last accepted word
// ---------------------------------------------------------------------------
module serializador_4bits #(
  parameter int NBITS_REG  = 4,
  parameter int BIT_CYCLES = 1    // 1..255
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NBITS_REG-1:0] dado_paralelo,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           seg
);

  localparam int IW = (NBITS_REG > 1) ? $clog2(NBITS_REG) : 1;
  localparam logic [7:0]    CNT_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBITS_REG - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [NBITS_REG-1:0] r_shift;
  logic [NBITS_REG-1:0] r_disp;
  logic [7:0]           r_cnt;
  logic [IW-1:0]        r_idx;
  logic                 r_serial;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_bit_end;
  logic [NBITS_REG-1:0] w_shift_nxt;
  logic [3:0]           w_nib;

  assign w_bit_end   = (r_cnt == CNT_LAST);
  assign w_shift_nxt = r_shift >> 1;

  // Outputs are driven from the state transition itself so that the line
  // value always matches the state entered on the same edge.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_disp   <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_serial <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
          r_idx    <= '0;
          // Also taken in the done cycle, giving back-to-back frames with a
          // single idle-high cycle between them.
          if (start) begin
            r_shift  <= dado_paralelo;
            r_disp   <= dado_paralelo;
            r_state  <= START;
            r_serial <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state  <= DATA;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_serial <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= w_shift_nxt;
            if (r_idx == IDX_LAST) begin
              r_state  <= STOP;
              r_idx    <= '0;
              r_serial <= 1'b1;
            end else begin
              r_idx    <= r_idx + IW'(1);
              r_serial <= w_shift_nxt[0];
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign serial_out = r_serial;
  assign busy       = r_busy;
  assign done       = r_done;

  // Display shows the low nibble of the latched word (zero-extended when
  // the word is narrower than 4 bits).
  assign w_nib = 4'(r_disp);

  always_comb begin
    seg = 8'h00;
    case (w_nib)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
      default: seg = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_serializador_4bits.sv
// Two instances (BIT_CYCLES=1 and 3) share stimulus; each is compared every
// cycle against a frame-level model that expands an accepted word into its
// list of line levels.
module tb_serializador_4bits;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dado_paralelo = 4'h0;
  bit         chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int BC = (g == 0) ? 1 : 3;

    logic       so, bz, dn;
    logic [7:0] sg;

    serializador_4bits #(.NBITS_REG(4), .BIT_CYCLES(BC)) dut (
      .clk_2        (clk_2),
      .reset        (reset),
      .start        (start),
      .dado_paralelo(dado_paralelo),
      .serial_out   (so),
      .busy         (bz),
      .done         (dn),
      .seg          (sg)
    );

    // Reference: q holds the line levels still to be sent after the current one.
    bit         q[$];
    bit         m_busy = 1'b0;
    bit         m_ser  = 1'b1;
    bit         m_done = 1'b0;
    logic [3:0] m_disp = 4'h0;
    int         n_done = 0;

    always @(posedge clk_2) begin
      if (reset) begin
        q.delete();
        m_busy = 1'b0; m_ser = 1'b1; m_done = 1'b0; m_disp = 4'h0;
      end else if (m_busy) begin
        if (q.size() > 0) begin
          m_ser = q.pop_front(); m_done = 1'b0;
        end else begin
          m_busy = 1'b0; m_ser = 1'b1; m_done = 1'b1; n_done++;
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          for (int b = 0; b < 6; b++) begin
            bit lvl;
            lvl = (b == 0) ? 1'b0 : (b == 5) ? 1'b1 : dado_paralelo[b-1];
            for (int c = 0; c < BC; c++) q.push_back(lvl);
          end
          m_disp = dado_paralelo;
          m_ser  = q.pop_front();
          m_busy = 1'b1;
        end else begin
          m_ser = 1'b1;
        end
      end
    end

    always @(negedge clk_2) begin
      if (chk_en) begin
        chk($sformatf("serial_bc%0d", BC), {7'd0, so}, {7'd0, m_ser});
        chk($sformatf("busy_bc%0d", BC),   {7'd0, bz}, {7'd0, m_busy});
        chk($sformatf("done_bc%0d", BC),   {7'd0, dn}, {7'd0, m_done});
        chk($sformatf("seg_bc%0d", BC),    sg, seg_tab[m_disp]);
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic [3:0] d);
    @(posedge clk_2); #2;
    reset = r; start = s; dado_paralelo = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, dado_paralelo);
  endtask

  initial begin
    // reset, then hold idle with start=0
    step(1'b1, 1'b1, 4'h7);   // start ignored under reset
    @(posedge clk_2); #2;
    chk_en = 1'b1;
    step(1'b1, 1'b0, 4'h0);
    idle(10);

    // single frame 4'hB
    step(1'b0, 1'b1, 4'hB);
    step(1'b0, 1'b0, 4'h3);
    idle(22);

    // start held high, back-to-back frames of 4'h5
    step(1'b0, 1'b1, 4'h5);
    for (int i = 0; i < 45; i++) step(1'b0, 1'b1, 4'h5);
    idle(22);

    // 4'hA frame with data change and second start mid-frame
    step(1'b0, 1'b1, 4'hA);
    step(1'b0, 1'b0, 4'hA);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h0);
    idle(22);

    // 4'hF frame aborted by reset during the data bits
    step(1'b0, 1'b1, 4'hF);
    idle(3);
    step(1'b1, 1'b0, 4'hF);
    idle(22);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0), 4'($urandom));
    idle(22);

    @(negedge clk_2); #1;
    chk("frames_done_bc1", {7'd0, (g_cfg[0].n_done > 0)}, 8'd1);
    chk("frames_done_bc3", {7'd0, (g_cfg[1].n_done > 0)}, 8'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
